seq_detector_param: RTL and testbench

- Parametrised serial bit-pattern detector; successor to the fixed 5-bit "10010" shift-register detector.
- Adds runtime-loadable pattern, input-valid qualification, overlap/non-overlap mode, fill tracking (no false matches before the window is full) and a saturating match counter.
- Sits on a serial bit stream behind a deserialiser or UART RX; z feeds frame-sync / interrupt logic.

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/seq_det_sat_cnt.sv | 25 ++
 rtl/seq_detector_param.sv | 87 ++++++++
 tb/tb_seq_detector_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants, fill-width helper and mode enum for the serial pattern detector.
package seq_det_pkg;

  localparam int          DEF_PAT_W   = 5;
  localparam int          DEF_CNT_W   = 8;
  localparam logic [4:0]  DEF_RST_PAT = 5'b10010;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } mode_e;

  // ceil(log2(n)); used to size the fill counter so it can hold 0..PAT_W
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter; clr wins first, then inc is applied to the cleared value.
module seq_det_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] base;
  logic [W-1:0] nxt;

  always_comb begin
    base = clr ? '0 : cnt;
    nxt  = (inc && (base != '1)) ? base + W'(1) : base;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= nxt;
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with loadable pattern, fill tracking and overlap control.
// Optional SEQ_DET_MASK_EN adds a per-bit don't-care mask loaded alongside the pattern.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_in,
  output logic [PAT_W-1:0] pat_mask_q,
`endif
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] pat_q
);

  localparam int FW = clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] sh;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] next_sh;
  logic [FW-1:0]    next_fill;
  logic             match;
  logic             hit;
  mode_e            mode;

  assign mode = mode_e'(overlap_en);

  // compare against the post-shift window so z lines up with the last pattern bit
  always_comb begin
    next_sh   = {sh[PAT_W-2:0], x};
    next_fill = (fill == FULL) ? fill : fill + FW'(1);
`ifdef SEQ_DET_MASK_EN
    match     = ((next_sh ^ pat_q) & pat_mask_q) == '0;
`else
    match     = (next_sh == pat_q);
`endif
    hit       = x_valid & ~pat_load & match & (next_fill == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh         <= '0;
      fill       <= '0;
      pat_q      <= RST_PAT;
      z          <= 1'b0;
`ifdef SEQ_DET_MASK_EN
      pat_mask_q <= '1;
`endif
    end else if (pat_load) begin
      sh         <= '0;
      fill       <= '0;
      pat_q      <= pat_in;
      z          <= 1'b0;
`ifdef SEQ_DET_MASK_EN
      pat_mask_q <= pat_mask_in;
`endif
    end else begin
      z <= hit;
      if (x_valid) begin
        sh   <= next_sh;
        // non-overlap restarts the window count; sh keeps shifting regardless
        fill <= (hit && mode == MODE_NONOVL) ? '0 : next_fill;
      end
    end
  end

  seq_det_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (hit),
    .cnt (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (PAT_W=5, CNT_W=2).
module tb_seq_detector_param;

  localparam int PAT_W = 5;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             x_valid;
  logic             x;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap_en;
  logic             cnt_clr;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic [PAT_W-1:0] pat_q;
`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] pat_mask_in;
  logic [PAT_W-1:0] pat_mask_q;
`endif

  int n_cmp = 0;
  int n_err = 0;

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W), .RST_PAT(5'b10010)) dut (
    .clk        (clk),
    .rst        (rst),
    .x_valid    (x_valid),
    .x          (x),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in(pat_mask_in),
    .pat_mask_q (pat_mask_q),
`endif
    .overlap_en (overlap_en),
    .cnt_clr    (cnt_clr),
    .z          (z),
    .match_cnt  (match_cnt),
    .pat_q      (pat_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b, input logic ez, input string tag);
    x_valid = 1'b1;
    x       = b;
    cyc();
    chk(tag, 32'(z), 32'(ez));
    x_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    x_valid = 1'b0;
    x       = 1'b1;
    repeat (n) begin
      cyc();
      chk("z_idle", 32'(z), 32'd0);
    end
  endtask

  // load a pattern and clear the counter in one cycle, with a live x bit that must be dropped
  task automatic reload(input logic [PAT_W-1:0] p);
    pat_load = 1'b1;
    pat_in   = p;
    cnt_clr  = 1'b1;
    x_valid  = 1'b1;
    x        = 1'b1;
    cyc();
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    x_valid  = 1'b0;
    chk("reload_pat_q", 32'(pat_q), 32'(p));
    chk("reload_fill", 32'(dut.fill), 32'd0);
    chk("reload_z", 32'(z), 32'd0);
    chk("reload_cnt", 32'(match_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] s8;
    logic [2:0] s3;
    logic [4:0] s5;
    rst = 1'b1; x_valid = 1'b1; x = 1'b1; pat_load = 1'b1; pat_in = 5'b11111;
    overlap_en = 1'b1; cnt_clr = 1'b0;
`ifdef SEQ_DET_MASK_EN
    pat_mask_in = 5'b00000;
`endif
    cyc();
    cyc();
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_pat_q", 32'(pat_q), 32'h12);
    chk("rst_fill", 32'(dut.fill), 32'd0);
`ifdef SEQ_DET_MASK_EN
    chk("rst_mask", 32'(pat_mask_q), 32'h1f);
`endif
    rst = 1'b0; pat_load = 1'b0; x_valid = 1'b0;

    // partial window never matches
    bit_in(1'b1, 1'b0, "fill_z1");
    bit_in(1'b0, 1'b0, "fill_z2");
    bit_in(1'b0, 1'b0, "fill_z3");
    bit_in(1'b1, 1'b0, "fill_z4");
    chk("fill_4", 32'(dut.fill), 32'd4);
    chk("fill_cnt", 32'(match_cnt), 32'd0);

    // overlapping: 10010010 -> hits at bits 5 and 8
    reload(5'b10010);
    overlap_en = 1'b1;
    s8 = 8'b10010010;
    for (int i = 7; i >= 0; i--) bit_in(s8[i], (i == 3) || (i == 0), "ovl_z");
    chk("ovl_cnt", 32'(match_cnt), 32'd2);

    // non-overlapping: only bit 5; extending with 010 completes a fresh window at bit 11
    reload(5'b10010);
    overlap_en = 1'b0;
    for (int i = 7; i >= 0; i--) bit_in(s8[i], (i == 3), "novl_z");
    chk("novl_cnt", 32'(match_cnt), 32'd1);
    s3 = 3'b010;
    for (int i = 2; i >= 0; i--) bit_in(s3[i], (i == 0), "novl_ext_z");
    chk("novl_ext_cnt", 32'(match_cnt), 32'd2);

    // valid gaps: z pulses once on the edge taking the last bit
    reload(5'b10010);
    overlap_en = 1'b1;
    s5 = 5'b10010;
    for (int i = 4; i >= 0; i--) begin
      bit_in(s5[i], (i == 0), "gap_z");
      idle(3);
    end
    chk("gap_cnt", 32'(match_cnt), 32'd1);

    // pattern load with x_valid=1 discards the bit and keeps the count
    pat_load = 1'b1; pat_in = 5'b01101; x_valid = 1'b1; x = 1'b1;
    cyc();
    pat_load = 1'b0; x_valid = 1'b0;
    chk("load_pat_q", 32'(pat_q), 32'h0d);
    chk("load_fill", 32'(dut.fill), 32'd0);
    chk("load_z", 32'(z), 32'd0);
    chk("load_cnt", 32'(match_cnt), 32'd1);
    s5 = 5'b01101;
    for (int i = 4; i >= 0; i--) bit_in(s5[i], (i == 0), "newpat_z");
    chk("newpat_cnt", 32'(match_cnt), 32'd2);

    // saturation at 3 over 7 overlapping hits
    reload(5'b10010);
    overlap_en = 1'b1;
    s5 = 5'b10010;
    for (int i = 4; i >= 0; i--) bit_in(s5[i], (i == 0), "sat_first_z");
    chk("sat_cnt1", 32'(match_cnt), 32'd1);
    for (int k = 2; k <= 7; k++) begin
      for (int i = 2; i >= 0; i--) bit_in(s3[i], (i == 0), "sat_z");
      chk("sat_cnt", 32'(match_cnt), (k > 3) ? 32'd3 : 32'(k));
    end
    // clear coinciding with a hit leaves exactly one
    bit_in(1'b0, 1'b0, "clr_z0");
    bit_in(1'b1, 1'b0, "clr_z1");
    cnt_clr = 1'b1;
    bit_in(1'b0, 1'b1, "clr_hit_z");
    cnt_clr = 1'b0;
    chk("clr_hit_cnt", 32'(match_cnt), 32'd1);
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    chk("clr_only_cnt", 32'(match_cnt), 32'd0);

`ifdef SEQ_DET_MASK_EN
    pat_mask_in = 5'b11011;
    reload(5'b10010);
    chk("mask_q", 32'(pat_mask_q), 32'h1b);
    s5 = 5'b10110;
    for (int i = 4; i >= 0; i--) bit_in(s5[i], (i == 0), "mask_hit_z");
    pat_mask_in = 5'b11011;
    reload(5'b10010);
    s5 = 5'b00010;
    for (int i = 4; i >= 0; i--) bit_in(s5[i], 1'b0, "mask_miss_z");
`endif

    // reset ignores a concurrent load and valid bit
    rst = 1'b1; pat_load = 1'b1; pat_in = 5'b00111; x_valid = 1'b1; x = 1'b0;
    cyc();
    rst = 1'b0; pat_load = 1'b0; x_valid = 1'b0;
    chk("rst2_pat_q", 32'(pat_q), 32'h12);
    chk("rst2_fill", 32'(dut.fill), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
